// File: rtl/seq_match_pkg.sv
// -----------------------------------------------------------------------------
// seq_match_pkg
// Shared types for the sequence-match detector.
//   mode_e  : compare mode selector carried on the 2-bit 'mode' input
//   state_e : detector FSM state, also exported on the debug port
// -----------------------------------------------------------------------------
package seq_match_pkg;

  typedef enum logic [1:0] {
    MODE_EQ   = 2'b00,   // s == r
    MODE_GE   = 2'b01,   // s >= r, unsigned
    MODE_LE   = 2'b10,   // s <= r, unsigned
    MODE_MASK = 2'b11    // (s & r) != 0
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,     // no match run in progress, count 0
    ST_ARM  = 2'b01,     // partial run, 0 < count < DEPTH
    ST_HIT  = 2'b10      // DEPTH consecutive matches seen, flag set
  } state_e;

endpackage

// File: rtl/seq_match_cmp.sv
// -----------------------------------------------------------------------------
// seq_match_cmp
// Purely combinational sample/reference comparator.
// Ports:
//   s    [WIDTH-1:0] in  sample word
//   r    [WIDTH-1:0] in  reference word
//   mode [1:0]       in  compare mode (see seq_match_pkg::mode_e)
//   hit              out compare result
// All comparisons are unsigned over the full WIDTH.
// -----------------------------------------------------------------------------
module seq_match_cmp
  import seq_match_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [1:0]       mode,
  output logic             hit
);

  always_comb begin
    hit = 1'b0;
    case (mode_e'(mode))
      MODE_EQ:   hit = (s == r);
      MODE_GE:   hit = (s >= r);
      MODE_LE:   hit = (s <= r);
      MODE_MASK: hit = ((s & r) != '0);
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_match_detect.sv
// -----------------------------------------------------------------------------
// seq_match_detect
// Registers the result of comparing each accepted sample against a reference
// and raises a detect flag after DEPTH consecutive accepted matches.
//
// Handshake: in_valid qualifies s/r/mode in the cycle it is high; the block
// always accepts (no ready). An accepted sample yields T with a one-cycle
// t_valid pulse on the next cycle. Cycles with in_valid low neither break nor
// advance a match run. clear has priority over a sample presented with it.
//
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   in_valid   in  sample qualifier
//   s, r       in  sample / reference words [WIDTH-1:0]
//   mode       in  compare mode [1:0]
//   clear      in  synchronous clear of count, flag and T
//   T          out registered compare result of last accepted sample
//   t_valid    out one-cycle pulse, T updated this cycle
//   f          out detect flag
//   match_cnt  out consecutive-match count, saturating at DEPTH
//   dbg_state  out current FSM state (seq_match_pkg::state_e encoding)
//
// Build option: define SEQ_MATCH_HYST_EN to make the flag release after DEPTH
// consecutive misses while in HIT. Without it the flag is sticky until clear
// or reset.
// -----------------------------------------------------------------------------
module seq_match_detect
  import seq_match_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           s,
  input  logic [WIDTH-1:0]           r,
  input  logic [1:0]                 mode,
  input  logic                       clear,
  output logic                       T,
  output logic                       t_valid,
  output logic                       f,
  output logic [$clog2(DEPTH+1)-1:0] match_cnt,
  output logic [1:0]                 dbg_state
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Reset release is brought through two flops so the FSM only starts
  // accepting samples once deassertion has been seen synchronously.
  logic [1:0] r_rst_sync;
  logic       w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run = r_rst_sync[1];

  logic w_hit;
  logic w_acc;

  seq_match_cmp #(.WIDTH(WIDTH)) u_cmp (
    .s    (s),
    .r    (r),
    .mode (mode),
    .hit  (w_hit)
  );

  assign w_acc = in_valid & w_run & ~clear;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_t;
  logic          r_t_valid;

`ifdef SEQ_MATCH_HYST_EN
  logic [CW-1:0] r_miss,  w_miss_nxt;
`endif

  // Next-state / count logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef SEQ_MATCH_HYST_EN
    w_miss_nxt  = r_miss;
`endif
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
`ifdef SEQ_MATCH_HYST_EN
      w_miss_nxt  = '0;
`endif
    end else if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            w_cnt_nxt   = ONE_C;
            w_state_nxt = (DEPTH == 1) ? ST_HIT : ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_hit) begin
            w_cnt_nxt = r_cnt + ONE_C;
            if ((r_cnt + ONE_C) == DEPTH_C) w_state_nxt = ST_HIT;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HIT: begin
          // count stays saturated while the flag is up
          w_cnt_nxt = DEPTH_C;
`ifdef SEQ_MATCH_HYST_EN
          if (w_hit) begin
            w_miss_nxt = '0;
          end else if ((r_miss + ONE_C) == DEPTH_C) begin
            w_miss_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_miss_nxt = r_miss + ONE_C;
          end
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef SEQ_MATCH_HYST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_miss <= '0;
    else        r_miss <= w_miss_nxt;
  end
`endif

  // Result register: T holds between accepted samples, cleared by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t       <= 1'b0;
      r_t_valid <= 1'b0;
    end else begin
      r_t_valid <= w_acc;
      if (clear)      r_t <= 1'b0;
      else if (w_acc) r_t <= w_hit;
    end
  end

  assign T         = r_t;
  assign t_valid   = r_t_valid;
  assign f         = (r_state == ST_HIT);
  assign match_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_match_detect.sv
// -----------------------------------------------------------------------------
// tb_seq_match_detect
// Bench for seq_match_detect: a DEPTH=3 instance (main) and a DEPTH=1
// instance sharing the same stimulus. Table vectors, directed multi-cycle
// sequences and a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_seq_match_detect;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       in_valid;
  logic [3:0] s;
  logic [3:0] r;
  logic [1:0] mode;
  logic       clear;

  logic       t_a, tv_a, f_a;
  logic [1:0] cnt_a;
  logic [1:0] dbg_a;
  logic       t_b, tv_b, f_b;
  logic [0:0] cnt_b;
  logic [1:0] dbg_b;

  seq_match_detect #(.WIDTH(4), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .r(r),
    .mode(mode), .clear(clear), .T(t_a), .t_valid(tv_a), .f(f_a),
    .match_cnt(cnt_a), .dbg_state(dbg_a)
  );

  seq_match_detect #(.WIDTH(4), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .s(s), .r(r),
    .mode(mode), .clear(clear), .T(t_b), .t_valid(tv_b), .f(f_b),
    .match_cnt(cnt_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are checked 1 time
  // unit after the following edge.
  task automatic drive(input logic v, input logic [3:0] ss, input logic [3:0] rr,
                       input logic [1:0] mm, input logic cc);
    in_valid = v; s = ss; r = rr; mode = mm; clear = cc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_hit(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    case (m)
      2'd0:    return a == b;
      2'd1:    return a >= b;
      2'd2:    return a <= b;
      default: return (a & b) != 4'd0;
    endcase
  endfunction

  int m_cnt[2];
  int m_miss[2];
  bit m_f[2];
  bit m_t[2];
  bit m_tv[2];
  int m_depth[2] = '{3, 1};

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_miss[k] = 0; m_f[k] = 0; m_t[k] = 0; m_tv[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit h, input bit c);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_cnt[k] = 0; m_miss[k] = 0; m_f[k] = 0; m_t[k] = 0; m_tv[k] = 0;
      end else if (v) begin
        m_t[k]  = h;
        m_tv[k] = 1;
        if (m_f[k]) begin
          if (h) m_miss[k] = 0;
`ifdef SEQ_MATCH_HYST_EN
          else begin
            m_miss[k]++;
            if (m_miss[k] == m_depth[k]) begin
              m_f[k] = 0; m_cnt[k] = 0; m_miss[k] = 0;
            end
          end
`endif
        end else if (h) begin
          m_cnt[k]++;
          if (m_cnt[k] == m_depth[k]) m_f[k] = 1;
        end else begin
          m_cnt[k] = 0;
        end
      end else begin
        m_tv[k] = 0;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [3:0] s;
    logic [3:0] r;
    logic [1:0] m;
    logic       c;
    logic       e_t;
    logic       e_tv;
    logic       e_f;
    logic [1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] ss, input logic [3:0] rr,
                              input logic [1:0] m, input logic c, input logic et,
                              input logic etv, input logic ef, input logic [1:0] ecnt);
    vec_t x;
    x.v = v; x.s = ss; x.r = rr; x.m = m; x.c = c;
    x.e_t = et; x.e_tv = etv; x.e_f = ef; x.e_cnt = ecnt;
    return x;
  endfunction

  vec_t tbl[17];

  // ---------------- test ----------------
  initial begin
    logic [4:0] e;
    bit         v_r, c_r, h_r;
    logic [3:0] s_r, r_r;
    logic [1:0] m_r;

    tbl[0]  = mk(1, 4'hA, 4'hA, 2'd0, 0, 1, 1, 0, 2'd1);
    tbl[1]  = mk(1, 4'hA, 4'hA, 2'd0, 0, 1, 1, 0, 2'd2);
    tbl[2]  = mk(1, 4'hA, 4'hA, 2'd0, 0, 1, 1, 1, 2'd3);
    tbl[3]  = mk(0, 4'h0, 4'h0, 2'd0, 0, 1, 0, 1, 2'd3);
    tbl[4]  = mk(1, 4'hA, 4'hA, 2'd0, 1, 0, 0, 0, 2'd0);
    tbl[5]  = mk(1, 4'h5, 4'h6, 2'd1, 0, 0, 1, 0, 2'd0);
    tbl[6]  = mk(1, 4'h6, 4'h6, 2'd1, 0, 1, 1, 0, 2'd1);
    tbl[7]  = mk(1, 4'h8, 4'h7, 2'd3, 0, 0, 1, 0, 2'd0);
    tbl[8]  = mk(1, 4'h3, 4'h9, 2'd2, 0, 1, 1, 0, 2'd1);
    tbl[9]  = mk(1, 4'hC, 4'h4, 2'd3, 0, 1, 1, 0, 2'd2);
    tbl[10] = mk(0, 4'h0, 4'h0, 2'd0, 0, 1, 0, 0, 2'd2);
    tbl[11] = mk(0, 4'h0, 4'h0, 2'd0, 0, 1, 0, 0, 2'd2);
    tbl[12] = mk(1, 4'hF, 4'hF, 2'd0, 0, 1, 1, 1, 2'd3);
    tbl[13] = mk(0, 4'h0, 4'h0, 2'd0, 1, 0, 0, 0, 2'd0);
    tbl[14] = mk(1, 4'h1, 4'h1, 2'd0, 0, 1, 1, 0, 2'd1);
    tbl[15] = mk(1, 4'h2, 4'h2, 2'd0, 0, 1, 1, 0, 2'd2);
    tbl[16] = mk(1, 4'h2, 4'h3, 2'd0, 0, 0, 1, 0, 2'd0);

    in_valid = 0; s = 0; r = 0; mode = 0; clear = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_T", t_a, 0);
    chk("rst_tv", tv_a, 0);
    chk("rst_f", f_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // table vectors
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].m, tbl[i].c);
      chk($sformatf("tbl%0d_T", i), t_a, tbl[i].e_t);
      chk($sformatf("tbl%0d_tv", i), tv_a, tbl[i].e_tv);
      chk($sformatf("tbl%0d_f", i), f_a, tbl[i].e_f);
      chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].e_cnt);
    end

    // HIT then three misses: flag release depends on the build option
    for (int i = 0; i < 3; i++) drive(1, 4'h7, 4'h7, 2'd0, 0);
    chk("hit_f", f_a, 1);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 4'h1, 4'h2, 2'd0, 0);
      chk($sformatf("miss%0d_T", i), t_a, 0);
`ifdef SEQ_MATCH_HYST_EN
      chk($sformatf("miss%0d_f", i), f_a, (i < 3) ? 1 : 0);
      chk($sformatf("miss%0d_cnt", i), cnt_a, (i < 3) ? 3 : 0);
`else
      chk($sformatf("miss%0d_f", i), f_a, 1);
      chk($sformatf("miss%0d_cnt", i), cnt_a, 3);
`endif
    end

    // asynchronous reset between edges while in ARM
    drive(0, 0, 0, 0, 1);
    drive(1, 4'h9, 4'h9, 2'd0, 0);
    chk("arm_cnt", cnt_a, 1);
    #3;
    rst_n = 0;
    #1;
    chk("async_T", t_a, 0);
    chk("async_tv", tv_a, 0);
    chk("async_f", f_a, 0);
    chk("async_cnt", cnt_a, 0);
    chk("async_f1", f_b, 0);
    in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    // first sample right after release falls inside the synchroniser window
    drive(1, 4'h9, 4'h9, 2'd0, 0);
    chk("sync_tv", tv_a, 0);
    chk("sync_f1", f_b, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 4'h9, 4'h9, 2'd0, 0);
    chk("fresh_cnt", cnt_a, 1);
    chk("fresh_f", f_a, 0);
    chk("d1_f", f_b, 1);
    chk("d1_T", t_b, 1);
    chk("d1_cnt", cnt_b, 1);

    // randomized run against the model
    drive(0, 0, 0, 0, 1);
    model_clear();
    for (int i = 0; i < 400; i++) begin
      v_r = ($urandom_range(0, 9) < 7);
      c_r = ($urandom_range(0, 24) == 0);
      m_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        s_r = 4'($urandom_range(0, 3));
        r_r = 4'($urandom_range(0, 3));
      end else begin
        s_r = 4'($urandom_range(0, 15));
        r_r = 4'($urandom_range(0, 15));
      end
      h_r = ref_hit(s_r, r_r, m_r);
      model_step(v_r, h_r, c_r);
      exp_q.push_back({m_t[0], m_tv[0], m_f[0], 2'(m_cnt[0])});
      drive(v_r, s_r, r_r, m_r, c_r);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_d3", i), {t_a, tv_a, f_a, cnt_a}, e);
      chk($sformatf("rnd%0d_d1", i), {t_b, tv_b, f_b, cnt_b},
          {m_t[1], m_tv[1], m_f[1], 1'(m_cnt[1])});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_match_detect.md
SEQ_MATCH_DETECT -- requirements
Module: seq_match_detect

Interface
REQ-001 Parameter WIDTH, default 4, bit width of sample s and reference r (legal 1..32).
REQ-002 Parameter DEPTH, default 3, consecutive-match count needed to raise f (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  s/r/mode qualified this cycle; block always accepts, no ready.
REQ-006 s  input  WIDTH  sample word.
REQ-007 r  input  WIDTH  reference word.
REQ-008 mode  input  2  compare mode: 00 EQ (s==r), 01 GE (s>=r unsigned), 10 LE (s<=r unsigned), 11 MASK ((s&r)!=0).
REQ-009 clear  input  1  synchronous clear of count and flag.
REQ-010 T  output  1  registered compare result of last accepted sample.
REQ-011 t_valid  output  1  one-cycle pulse, T updated this cycle.
REQ-012 f  output  1  detect flag, DEPTH consecutive matches seen.
REQ-013 match_cnt  output  $clog2(DEPTH+1)  current consecutive-match count, saturating at DEPTH.

Function
REQ-014 Sample accepted in cycle n (in_valid=1) shall produce T and t_valid=1 in cycle n+1; latency exactly 1.
REQ-015 T shall hold its value while in_valid=0; t_valid shall be 0 in those cycles.
REQ-016 Cycles with in_valid=0 shall not break or advance a match sequence.
REQ-017 FSM states IDLE (cnt=0, f=0), ARM (0<cnt<DEPTH, f=0), HIT (f=1).
REQ-018 IDLE: accepted match -> cnt=1, to ARM; if DEPTH=1 go directly to HIT.
REQ-019 ARM: accepted match -> cnt+1, to HIT when cnt+1==DEPTH; accepted miss -> cnt=0, to IDLE.
REQ-020 HIT: match_cnt saturates at DEPTH; behaviour on miss defined by REQ-027/REQ-028.
REQ-021 f shall assert in the same cycle as the T that completes the DEPTH-th consecutive match.
REQ-022 clear=1 shall in next cycle force IDLE, cnt=0, f=0, T=0, t_valid=0; a sample presented with clear is dropped (clear wins).
REQ-023 All comparisons unsigned, full WIDTH, no truncation; mode sampled with the same in_valid as s/r.

Reset
REQ-024 rst_n low shall immediately force IDLE, T=0, t_valid=0, f=0, match_cnt=0, independent of clk.
REQ-025 Reset asserted mid-sequence shall discard partial count; first accepted sample after release starts fresh.
REQ-026 Reset deassertion shall be synchronised internally before FSM leaves IDLE.

Configuration
REQ-027 Macro SEQ_MATCH_HYST_EN defined: in HIT, a miss counter tracks consecutive accepted misses; at DEPTH misses f deasserts, cnt=0, to IDLE; any accepted match resets miss counter.
REQ-028 Macro undefined: f is sticky in HIT, cleared only by clear or rst_n; no miss counter present.

Structure
REQ-029 Package seq_match_pkg shall hold mode enum (MODE_EQ, MODE_GE, MODE_LE, MODE_MASK) and FSM state enum (ST_IDLE, ST_ARM, ST_HIT).
REQ-030 Combinational compare shall live in sub-module seq_match_cmp (WIDTH param; s, r, mode -> hit); all state in seq_match_detect.

Verification
REQ-031 WIDTH=4, DEPTH=3, mode EQ, s=r=4'hA on 3 consecutive valid cycles -> T=1 each; f=1 with 3rd T, match_cnt=3.
REQ-032 Mode GE, s=4'h5/r=4'h6 -> T=0; s=4'h6/r=4'h6 -> T=1; mode MASK s=4'h8/r=4'h7 -> T=0.
REQ-033 Two matches, 2 idle cycles, third match -> f=1; two matches then a miss -> match_cnt=0, f=0.
REQ-034 In HIT, clear with in_valid=1 and matching sample -> next cycle f=0, match_cnt=0, t_valid=0.
REQ-035 With SEQ_MATCH_HYST_EN, HIT then 3 misses -> f drops with 3rd T; without macro f stays 1.
REQ-036 rst_n pulsed low between clock edges in ARM -> outputs 0 immediately; DEPTH=1 single match afterwards -> f=1 next cycle.
